// File: rtl/dsp_cfg_pkg.sv
// Shared types and constants for the DSP configuration-chain loader.
// Holds the FSM state encoding, the CRC-16-CCITT constants and counter-width helpers.
package dsp_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // Bit counter must be able to hold the value n itself.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dsp_cfg_crc16.sv
// Serial CRC-16-CCITT (MSB-first feedback), updates one bit per enabled cycle.
// Latency: value reflects a bit on the cycle after it is presented; no backpressure.
module dsp_cfg_crc16
   import dsp_cfg_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        bit_in,
   input  logic        en,
   input  logic        clr,
   output logic [15:0] crc
);

   logic fb;

   assign fb = crc[15] ^ bit_in;

   always_ff @(posedge clk) begin
      if (!reset_n || clr) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
   end

endmodule

// File: rtl/dsp_config_loader.sv
// Shifts CHAIN_LEN bits from a valid/ready word stream into a DSP config chain, LSB first;
// first enable 2 cycles after start, stalls in LOAD when s_valid is low. Optional CRC: DSP_CFG_CRC_EN.
module dsp_config_loader
   import dsp_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 40,
   parameter int WORD_W    = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [WORD_W-1:0] s_data,
   output logic              s_ready,
   output logic              configuration_output,
   output logic              configuration_enable,
   output logic              busy,
`ifdef DSP_CFG_CRC_EN
   input  logic [15:0]       crc_ref,
   output logic              crc_err,
`endif
   output logic              done
);

   localparam int CW = cnt_width(CHAIN_LEN);
   localparam int BW = idx_width(WORD_W);
   localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
   localparam logic [BW-1:0] LAST_IDX = BW'(WORD_W - 1);

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     bit_cnt;
   logic [BW-1:0]     bit_idx;
   logic [WORD_W-1:0] word;
   logic              final_bit;
   logic              word_end;
   logic              accept;

   assign final_bit = (bit_cnt == LAST_BIT);
   assign word_end  = (bit_idx == LAST_IDX);
   assign accept    = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_LOAD;
         ST_LOAD:  if (accept) state_nxt = ST_SHIFT;
         ST_SHIFT: begin
            if (final_bit) begin
               state_nxt = ST_DONE;
            end else if (word_end && !accept) begin
               state_nxt = ST_LOAD;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (abort) begin
         state_nxt = ST_IDLE;
      end
   end

   // A word taken on the last bit of the previous one still counts that last bit.
   always_ff @(posedge clk) begin
      if (!reset_n || abort || state == ST_IDLE) begin
         bit_cnt <= '0;
         bit_idx <= '0;
         word    <= '0;
      end else if (accept) begin
         word    <= s_data;
         bit_idx <= '0;
         if (state == ST_SHIFT) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end else if (state == ST_SHIFT) begin
         word    <= word >> 1;
         bit_idx <= bit_idx + 1'b1;
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_comb begin
      s_ready              = 1'b0;
      configuration_output = 1'b0;
      configuration_enable = 1'b0;
      done                 = 1'b0;
      busy                 = (state != ST_IDLE);
      case (state)
         ST_LOAD:  s_ready = !abort;
         ST_SHIFT: begin
            configuration_enable = 1'b1;
            configuration_output = word[0];
            s_ready              = word_end && !final_bit && !abort;
         end
         ST_DONE:  done = 1'b1;
         default:  ;
      endcase
   end

`ifdef DSP_CFG_CRC_EN
   logic [15:0] crc_val;
   logic [15:0] crc_ref_q;
   logic        crc_clr;
   logic        err_q;
   logic        mism;

   assign crc_clr = (state == ST_IDLE) && start && !abort;
   assign mism    = (state == ST_DONE) && (crc_val != crc_ref_q);

   dsp_cfg_crc16 u_crc (
      .clk     (clk),
      .reset_n (reset_n),
      .bit_in  (configuration_output),
      .en      (configuration_enable),
      .clr     (crc_clr),
      .crc     (crc_val)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         err_q     <= 1'b0;
         crc_ref_q <= '0;
      end else if (crc_clr) begin
         err_q     <= 1'b0;
         crc_ref_q <= crc_ref;
      end else if (mism) begin
         err_q     <= 1'b1;
      end
   end

   // Visible during the done pulse itself, then held by err_q.
   assign crc_err = err_q | mism;
`endif

endmodule

// File: doc/dsp_config_loader.md
DSP_CONFIG_LOADER -- requirements
Module: dsp_config_loader

Interface
REQ-001 The module SHALL have parameter CHAIN_LEN, default 40: total configuration-chain bits to shift, legal range 1..4096.
REQ-002 The module SHALL have parameter WORD_W, default 8: width of each input image word, legal range 1..32.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: one-cycle request to begin a load; honoured only in IDLE.
REQ-006 The module SHALL have port abort, input, 1 bit: cancels a load in progress.
REQ-007 The module SHALL have port s_valid, input, 1 bit: image word valid.
REQ-008 The module SHALL have port s_data, input, WORD_W bits: image word, shifted LSB first.
REQ-009 The module SHALL have port s_ready, output, 1 bit: loader accepts s_data this cycle.
REQ-010 The module SHALL have port configuration_output, output, 1 bit: serial bit driven to the DSP configuration_input.
REQ-011 The module SHALL have port configuration_enable, output, 1 bit: chain shift enable to the DSP.
REQ-012 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle pulse after the final bit is shifted.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE.
REQ-015 Transitions SHALL be:
- IDLE to LOAD on start.
- LOAD to SHIFT on s_valid&&s_ready.
- SHIFT to LOAD when the word is exhausted, bits remain and no word is accepted.
- SHIFT to DONE when the bit counter reaches CHAIN_LEN.
- DONE to IDLE unconditionally.
REQ-016 s_ready SHALL be high in LOAD, and also in SHIFT on the last bit of the current word when more than that bit remains; a word accepted this way starts shifting the next cycle with no bubble.
REQ-017 In SHIFT, configuration_enable SHALL be 1 and configuration_output SHALL equal the current word bit, one bit per cycle, LSB first.
REQ-018 In every state other than SHIFT, configuration_enable SHALL be 0 and configuration_output SHALL be 0.
REQ-019 With s_valid held high, configuration_enable SHALL be high for exactly CHAIN_LEN contiguous cycles, starting 2 cycles after start.
REQ-020 If s_valid is low when a word is exhausted, the FSM SHALL wait in LOAD with configuration_enable low, so the chain holds its state.
REQ-021 The final word SHALL be truncated to the remaining bit count (CHAIN_LEN mod WORD_W when nonzero); its unused upper bits SHALL be discarded.
REQ-022 The bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never exceed CHAIN_LEN.
REQ-023 abort in any non-IDLE state SHALL return the FSM to IDLE the next cycle, with configuration_enable low, done not pulsed and counters cleared; abort SHALL take priority over all transitions.
REQ-024 start while busy SHALL be ignored; start and abort asserted together in IDLE SHALL leave the FSM in IDLE.

Reset
REQ-025 While reset_n=0 at a clock edge, the state SHALL become IDLE and counters and the word register SHALL clear.
REQ-026 Output reset values SHALL be: s_ready=0, configuration_output=0, configuration_enable=0, busy=0, done=0, and crc_err=0 when present.
REQ-027 Reset mid-load SHALL act as abort, and the partially shifted chain contents SHALL be left undefined.

Configuration
REQ-028 Macro DSP_CFG_CRC_EN SHALL compile in the port crc_ref (input, 16 bits, sampled on start) and the port crc_err (output, 1 bit).
REQ-029 With DSP_CFG_CRC_EN defined, a CRC-16-CCITT SHALL be computed serially over the shifted bits: polynomial 0x1021, init 0xFFFF, updated only when configuration_enable=1.
REQ-030 With DSP_CFG_CRC_EN defined, crc_err SHALL be set in DONE when the computed CRC differs from crc_ref, and SHALL hold until the next start or reset.
REQ-031 Without DSP_CFG_CRC_EN, neither the ports nor the CRC logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-032 The state enum, the CRC polynomial and init constants, and the function computing the counter width SHALL live in shared package dsp_cfg_pkg.
REQ-033 The CRC engine SHALL be one sub-module, dsp_cfg_crc16 (bit input, enable, clear, 16-bit value), instantiated only under DSP_CFG_CRC_EN.

Verification
REQ-034 CHAIN_LEN=40, WORD_W=8, start then s_valid held high with words 0x01..0x05 -> configuration_enable high for cycles 2..41 after start; serial bits follow 0x01 LSB first, then 0x02, and so on; done pulses at cycle 42.
REQ-035 CHAIN_LEN=20, WORD_W=8, words 0xFF,0xFF,0xAB -> 20 bits shifted; last word contributes bits 0xB LSB first (1,1,0,1); s_ready stays low after the third word.
REQ-036 s_valid dropped for 3 cycles after the second word -> configuration_enable low for those 3 cycles plus the reload cycle; total enable-high cycles stay at 40.
REQ-037 abort asserted on the 17th shift cycle -> the next cycle is IDLE, busy=0, configuration_enable=0, no done; a following start restarts from bit 0.
REQ-038 reset_n low for 1 cycle mid-SHIFT -> all outputs at reset values on the next cycle; start during reset is ignored.
REQ-039 DSP_CFG_CRC_EN defined, CHAIN_LEN=8, data 0x00, crc_ref matching the reference-model CRC -> crc_err=0; the same run with crc_ref^0x0001 -> crc_err=1 at done.
